// File: rtl/mips_instr_encoder_if.sv
// mips_instr_encoder_if: loader request bus and instruction-memory write port
interface mips_instr_encoder_if #(parameter int ADDR_W = 6);
  logic start;
  logic stop;
  logic in_valid;
  logic in_ready;
  logic [4:0] mnem;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;
  logic [15:0] imm;
  logic [25:0] target;
  logic im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0] im_wdata;
  logic err;
  logic [ADDR_W:0] count;
  logic full;
  modport master (
    output start, stop, in_valid, mnem, rs, rt, rd, imm, target,
    input  in_ready, im_we, im_addr, im_wdata, err, count, full
  );
  modport slave (
    input  start, stop, in_valid, mnem, rs, rt, rd, imm, target,
    output in_ready, im_we, im_addr, im_wdata, err, count, full
  );
endinterface

// File: rtl/mips_instr_encoder.sv
// mips_instr_encoder: symbolic instruction to MIPS word encoder filling IM at consecutive addresses
module mips_instr_encoder #(
  parameter int ADDR_W = 6
) (
  input logic clk,
  input logic rst_n,
  mips_instr_encoder_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] FULL = 2'd2;
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'((1 << ADDR_W) - 1);
  logic [1:0] state;
  logic [5:0] code;
  logic [31:0] word;
  logic illegal;
  logic accept;
  logic wr;
  // code is the R-type func for mnemonics 0..7 and the primary opcode otherwise
  always_comb begin
    code = 6'h00;
    case (bus.mnem)
      5'd0:  code = 6'h20;
      5'd1:  code = 6'h22;
      5'd2:  code = 6'h24;
      5'd3:  code = 6'h25;
      5'd4:  code = 6'h26;
      5'd5:  code = 6'h27;
      5'd6:  code = 6'h2b;
      5'd7:  code = 6'h04;
      5'd9:  code = 6'h08;
      5'd10: code = 6'h0c;
      5'd11: code = 6'h0e;
      5'd12: code = 6'h0b;
      5'd13: code = 6'h23;
      5'd14: code = 6'h2b;
      5'd15: code = 6'h04;
      5'd16: code = 6'h05;
      5'd17: code = 6'h02;
      5'd18: code = 6'h03;
      default: code = 6'h00;
    endcase
  end
  assign word = bus.mnem < 5'd8  ? {6'h00, bus.rs, bus.rt, bus.rd, 5'b0, code} :
                bus.mnem == 5'd8 ? {6'h00, bus.rs, 15'b0, 6'b001000} :
                bus.mnem < 5'd17 ? {code, bus.rs, bus.rt, bus.imm} :
                                   {code, bus.target};
  assign illegal = bus.mnem > 5'd18;
  assign bus.in_ready = state == LOAD;
  assign bus.full = state == FULL;
  assign accept = bus.in_valid & bus.in_ready;
  assign wr = accept & ~illegal;
  // count doubles as the write pointer; it never wraps because FULL stops accepts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      bus.im_we <= 1'b0;
      bus.err <= 1'b0;
      bus.im_addr <= '0;
      bus.im_wdata <= '0;
      bus.count <= '0;
    end else begin
      bus.im_we <= wr;
      bus.err <= accept & illegal;
      if (wr) begin
        bus.im_addr <= bus.count[ADDR_W-1:0];
        bus.im_wdata <= word;
      end
      if (bus.start) begin
        state <= LOAD;
        bus.count <= '0;
      end else begin
        if (wr) bus.count <= bus.count + 1'b1;
        if (bus.stop) state <= IDLE;
        else if (wr && bus.count == LAST) state <= FULL;
      end
    end
  end
endmodule
